apb_sram_slave: RTL
===================

Name: apb_sram_slave

Overview:
- Synthesizable APB3 completer with word-addressed SRAM storage, one per psel_o bit of the AXI-to-APB bridge.
- Directly downstream of the bridge; replaces the behavioural bench slave so the bridge can be run against RTL.
- Inserts programmable wait states and flags error responses for out-of-region or misaligned accesses.
- Provides a backdoor write port for preload.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width (fixed at 32 for this block)
REGION_START, 32'h0001_F000, base byte address of the decoded region
REGION_SIZE, 32'h0000_1000, region size in bytes (power of two, >= 4)
WAIT_STATES, 1, ACCESS-phase cycles with pready low before completion (0..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high
psel_i  in  1  slave select
penable_i  in  1  access phase
pwrite_i  in  1  1 = write
paddr_i  in  ADDR_WIDTH  byte address
pwdata_i  in  DATA_WIDTH  write data
prdata_o  out  DATA_WIDTH  read data, registered
pready_o  out  1  transfer complete
pslverr_o  out  1  error response, valid only with pready_o
bd_we_i  in  1  backdoor write request
bd_addr_i  in  ADDR_WIDTH  backdoor byte address
bd_wdata_i  in  DATA_WIDTH  backdoor data
bd_ready_o  out  1  backdoor write accepted this cycle

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-high. Reset is in effect while rst_n = 1.
- Reset values: state IDLE, prdata_o = 0, pready_o = 0, pslverr_o = 0, bd_ready_o = 0, wait counter = 0. Memory contents are not reset.
- Storage: REGION_SIZE/4 words, indexed by (paddr - REGION_START) >> 2.
- Error flag err = paddr outside [REGION_START, REGION_START+REGION_SIZE) OR paddr[1:0] != 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - On psel_i & !penable_i (SETUP), capture addr, pwrite, pwdata and err.
  - Load counter = WAIT_STATES.
  - Register prdata_o = err ? 0 : mem[idx] (reads only; prdata_o holds on writes).
  - Go to ACCESS.
- ACCESS:
  - pready_o = (counter == 0); it is driven from registered state, so there is no combinational path from inputs.
  - While penable_i and counter != 0: decrement.
  - Completion cycle (psel_i & penable_i & pready_o):
    - pslverr_o = captured err.
    - If write and !err: mem[idx] <= captured pwdata at this clock edge.
    - Next state DONE.
  - With WAIT_STATES = 0, completion is the first ACCESS cycle, giving the minimum 2-cycle APB transfer.
- DONE:
  - pready_o and pslverr_o are low.
  - If psel_i & !penable_i, treat as a new SETUP (back-to-back, same capture as IDLE), otherwise go to IDLE.
- Protocol violations:
  - psel_i drops during ACCESS: abort to IDLE, no memory write, pready_o stays 0.
  - penable_i high in IDLE without a prior SETUP: ignored; stay IDLE, no response.
- Error transfers never modify memory. Error reads return prdata_o = 0.
- Backdoor:
  - bd_ready_o = bd_we_i & (state == IDLE) & !(psel_i).
  - When bd_ready_o is high, the write commits at the clock edge; out-of-region backdoor addresses are dropped silently.
  - If an APB SETUP arrives in the same cycle, APB wins and the backdoor write is held off. The requester keeps bd_we_i high until bd_ready_o.
- Reset mid-transfer: immediate return to IDLE with outputs cleared. A pending write is not committed.
- Region-address arithmetic is done at ADDR_WIDTH; offset subtraction uses unsigned compare, with no wrap past 2^ADDR_WIDTH.

Decomposition:
- Shared package apb_pkg: state enum (IDLE/ACCESS/DONE), APB_DATA_WIDTH, APB_ADDR_WIDTH, helper function in_region(addr, start, size).
- One natural sub-module: apb_sram_mem (single-port synchronous-write, asynchronous-read word array, parameter DEPTH).
- The FSM, error decode and backdoor arbitration stay in apb_sram_slave.

Test Plan:
- WAIT_STATES=1, write 0xDEADBEEF to 0x0001_F010, then read the same address -> write shows pready high on 2nd ACCESS cycle, pslverr 0; read returns prdata 0xDEADBEEF.
- WAIT_STATES=0, back-to-back reads of 0x0001_F000 and 0x0001_F004 after backdoor preload of 0x11111111/0x22222222 -> each completes in 2 cycles with the correct data; DONE→SETUP path is exercised.
- Write to 0x0002_0000 (out of region) and to 0x0001_F002 (misaligned) -> pready with pslverr 1; a subsequent backdoor-free read of 0x0001_F000 is unchanged.
- Deassert psel_i mid-ACCESS of a write with WAIT_STATES=3 -> FSM returns to IDLE, pready never asserts, memory is unchanged.
- bd_we_i held high while APB SETUP arrives -> bd_ready_o = 0 until the FSM returns to IDLE, then 1 for one cycle, and the word is written.
- Assert rst_n=1 during ACCESS of a write -> outputs go to 0 asynchronously; after release, the target word holds its old value.

Source files
------------

// File: rtl/apb_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared APB types, widths and region-decode helper for the
//               APB SRAM completer.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } apb_state_e;

    // Unsigned window test; the subtraction only happens once addr >= start,
    // so the offset never wraps past the top of the address space.
    function automatic logic in_region(
        input logic [APB_ADDR_WIDTH-1:0] addr,
        input logic [APB_ADDR_WIDTH-1:0] start,
        input logic [APB_ADDR_WIDTH-1:0] size
    );
        return (addr >= start) && ((addr - start) < size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_sram_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_sram_slave_if
// Description : APB3 completer-side bus bundle with master/slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_sram_slave_if #(
    parameter int ADDR_WIDTH = apb_pkg::APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = apb_pkg::APB_DATA_WIDTH
) ();

    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [DATA_WIDTH-1:0] pwdata_i;
    logic [DATA_WIDTH-1:0] prdata_o;
    logic                  pready_o;
    logic                  pslverr_o;

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

endinterface
`default_nettype wire

// File: rtl/apb_sram_slave_mem.sv
`default_nettype none
// ============================================================================
// Module      : apb_sram_mem
// Description : Single-port word array, synchronous write, asynchronous read.
//               Contents are deliberately not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_sram_mem #(
    parameter  int DEPTH      = 1024,
    parameter  int DATA_WIDTH = 32,
    localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Commit a word on the clock edge when the single port is in write mode.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/apb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : apb_sram_slave
// Description : APB3 completer backed by a word SRAM. Programmable wait
//               states, error response on out-of-region or misaligned
//               accesses, and a backdoor write port for preload.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_sram_slave
    import apb_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = APB_ADDR_WIDTH,
    parameter int                    DATA_WIDTH   = APB_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] REGION_START = 32'h0001_F000,
    parameter logic [ADDR_WIDTH-1:0] REGION_SIZE  = 32'h0000_1000,
    parameter int                    WAIT_STATES  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apb_sram_slave_if.slave       apb,
    input  logic                  bd_we_i,
    input  logic [ADDR_WIDTH-1:0] bd_addr_i,
    input  logic [DATA_WIDTH-1:0] bd_wdata_i,
    output logic                  bd_ready_o
);

    localparam int         DEPTH     = int'(REGION_SIZE >> 2);
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    apb_state_e            state_q,  state_d;
    logic [3:0]            cnt_q,    cnt_d;
    logic [IDX_W-1:0]      idx_q,    idx_d;
    logic                  write_q,  write_d;
    logic                  err_q,    err_d;
    logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  w_setup;
    logic                  w_p_err;
    logic [IDX_W-1:0]      w_p_idx;
    logic                  w_bd_in;
    logic [IDX_W-1:0]      w_bd_idx;
    logic                  w_ready;
    logic                  w_complete;
    logic                  w_bd_ready;
    logic                  w_mem_we;
    logic [IDX_W-1:0]      w_mem_addr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic [DATA_WIDTH-1:0] w_mem_rdata;

    assign w_setup  = apb.psel_i & ~apb.penable_i;
    assign w_p_err  = ~in_region(apb.paddr_i, REGION_START, REGION_SIZE)
                    | (apb.paddr_i[1:0] != 2'b00);
    assign w_p_idx  = IDX_W'((apb.paddr_i - REGION_START) >> 2);
    assign w_bd_in  = in_region(bd_addr_i, REGION_START, REGION_SIZE);
    assign w_bd_idx = IDX_W'((bd_addr_i - REGION_START) >> 2);

    // Ready depends only on registered state, keeping inputs off the pready path.
    assign w_ready    = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign w_complete = apb.psel_i & apb.penable_i & w_ready;

    // Backdoor only gets the port while the bus is idle and not being selected;
    // held low during reset so nothing commits while the block is in reset.
    assign w_bd_ready = bd_we_i & (state_q == IDLE) & ~apb.psel_i & ~rst_n;

    // One shared port: ACCESS writes the captured word, IDLE serves the
    // backdoor, and any SETUP reads the word addressed on the bus.
    assign w_mem_we    = (w_complete & write_q & ~err_q) | (w_bd_ready & w_bd_in);
    assign w_mem_addr  = (state_q == ACCESS) ? idx_q
                       : (w_bd_ready ? w_bd_idx : w_p_idx);
    assign w_mem_wdata = (state_q == ACCESS) ? wdata_q : bd_wdata_i;

    apb_sram_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_mem_we),
        .addr_i  (w_mem_addr),
        .wdata_i (w_mem_wdata),
        .rdata_o (w_mem_rdata)
    );

    // Next-state and capture logic for the SETUP / ACCESS / DONE sequence.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        prdata_d = prdata_q;
        case (state_q)
            IDLE, DONE: begin
                if (w_setup) begin
                    idx_d   = w_p_idx;
                    write_d = apb.pwrite_i;
                    err_d   = w_p_err;
                    wdata_d = apb.pwdata_i;
                    cnt_d   = WAIT_INIT;
                    if (!apb.pwrite_i) begin
                        prdata_d = w_p_err ? '0 : w_mem_rdata;
                    end
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (!apb.psel_i) begin
                    state_d = IDLE;
                end else if (w_complete) begin
                    state_d = DONE;
                end else if (apb.penable_i && (cnt_q != 4'd0)) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and capture registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
        end
    end

    assign apb.prdata_o  = prdata_q;
    assign apb.pready_o  = w_ready;
    assign apb.pslverr_o = w_ready & err_q;
    assign bd_ready_o    = w_bd_ready;

endmodule
`default_nettype wire
